regfile_dump: RTL and testbench

REGFILE_DUMP -- requirements
Module: regfile_dump

---
 rtl/regfile_dump_if.sv | 31 +++
 rtl/regfile_dump.sv | 102 ++++++++++
 tb/tb_regfile_dump.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// Bundles the register-file debug read port and the outgoing dump stream.
// The master side is the dump engine; the slave side is the register file and the stream consumer together.
interface regfile_dump_if;
    logic [4:0]  debug_raddr;
    logic [31:0] debug_reg;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output debug_raddr,
        input  debug_reg,
        output out_valid,
        input  out_ready,
        output out_index,
        output out_data,
        output out_last
    );

    modport slave (
        input  debug_raddr,
        output debug_reg,
        input  out_valid,
        output out_ready,
        input  out_index,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/regfile_dump.sv
// Walks the register file through its debug read port and streams each register out as one beat.
// Register 31 is always the final beat; done pulses for one cycle after that beat is accepted.
module regfile_dump #(
    parameter bit SKIP_X0 = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    regfile_dump_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_e;

    localparam logic [4:0] FIRST_REG = SKIP_X0 ? 5'd1 : 5'd0;
    localparam logic [4:0] LAST_REG  = 5'd31;

    state_e      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [4:0]  index_q, index_d;
    logic [31:0] data_q, data_d;
    logic        last_q, last_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= 5'd0;
            index_q <= 5'd0;
            data_q  <= 32'd0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            index_q <= index_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Abort outranks everything, including a handshake on the final beat, so it never yields done.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        index_d = index_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = FETCH;
                    ptr_d   = FIRST_REG;
                end
            end
            FETCH: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    data_d  = bus.debug_reg;
                    index_d = ptr_q;
                    last_d  = (ptr_q == LAST_REG);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d   = ptr_q + 5'd1;
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o          = (state_q != IDLE);
    assign done_o          = done_q;
    assign bus.out_valid   = (state_q == SEND);
    assign bus.debug_raddr = (state_q == FETCH) ? ptr_q : 5'd0;
    assign bus.out_index   = index_q;
    assign bus.out_data    = data_q;
    assign bus.out_last    = last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a table of scan scenarios checked beat by beat against an expected-beat queue,
// plus hand-written sequences for abort, start/abort collision and asynchronous reset.
module tb_regfile_dump;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b1;
    logic start0 = 1'b0, abort0 = 1'b0, ready0 = 1'b1;
    logic busy1, done1, busy0, done0;
    logic [31:0] regs [32];

    regfile_dump_if bus1 ();
    regfile_dump_if bus0 ();

    regfile_dump #(.SKIP_X0(1'b1)) dut1 (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (start1),
        .abort_i (abort1),
        .busy_o  (busy1),
        .done_o  (done1),
        .bus     (bus1)
    );

    regfile_dump #(.SKIP_X0(1'b0)) dut0 (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (start0),
        .abort_i (abort0),
        .busy_o  (busy0),
        .done_o  (done0),
        .bus     (bus0)
    );

    // x0 reads as zero, as on a RISC-V register file.
    assign bus1.debug_reg = (bus1.debug_raddr == 5'd0) ? 32'd0 : regs[bus1.debug_raddr];
    assign bus0.debug_reg = (bus0.debug_raddr == 5'd0) ? 32'd0 : regs[bus0.debug_raddr];
    assign bus1.out_ready = ready1;
    assign bus0.out_ready = ready0;

    always #5 clk = ~clk;

    int vecCount = 0;
    int missCount = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        bit sel;
        int readyPct;
        int abortIdx;
        int stallIdx;
        int pokeIdx;
        bit randData;
        int expBeats;
        int expDone;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic s, input logic a, input logic r);
        if (sel) begin
            start1 = s; abort1 = a; ready1 = r;
        end else begin
            start0 = s; abort0 = a; ready0 = r;
        end
    endtask

    task automatic sampleOut(input bit sel, output logic v, output logic [4:0] idx,
                             output logic [31:0] d, output logic l, output logic b,
                             output logic dn, output logic [4:0] ra);
        if (sel) begin
            v = bus1.out_valid; idx = bus1.out_index; d = bus1.out_data; l = bus1.out_last;
            b = busy1; dn = done1; ra = bus1.debug_raddr;
        end else begin
            v = bus0.out_valid; idx = bus0.out_index; d = bus0.out_data; l = bus0.out_last;
            b = busy0; dn = done0; ra = bus0.debug_raddr;
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
    endtask

    task automatic checkAllZero(input bit sel, input string tag);
        logic v, l, b, dn;
        logic [4:0] idx, ra;
        logic [31:0] d;
        sampleOut(sel, v, idx, d, l, b, dn, ra);
        checkOutput({tag, "_valid"}, 32'(v), 32'd0);
        checkOutput({tag, "_index"}, 32'(idx), 32'd0);
        checkOutput({tag, "_data"}, d, 32'd0);
        checkOutput({tag, "_last"}, 32'(l), 32'd0);
        checkOutput({tag, "_busy"}, 32'(b), 32'd0);
        checkOutput({tag, "_done"}, 32'(dn), 32'd0);
        checkOutput({tag, "_raddr"}, 32'(ra), 32'd0);
    endtask

    // Expected beats come straight from the register contents at scan start: first..31, x0 reads 0.
    task automatic runScan(input vec_t row, output int beats, output int doneCnt);
        beat_t expQ[$];
        beat_t eb;
        logic v, l, b, dn, s, a, r;
        logic [4:0] idx, ra;
        logic [31:0] d;
        int cyc, lastHsCyc, abortCyc, stall;
        bit firstSeen, finished;

        for (int i = (row.sel ? 1 : 0); i < 32; i++) begin
            eb.idx  = 5'(i);
            eb.data = (i == 0) ? 32'd0 : regs[i];
            expQ.push_back(eb);
        end
        beats = 0; doneCnt = 0; cyc = 0; lastHsCyc = -10; abortCyc = -10; stall = 0;
        firstSeen = 1'b0; finished = 1'b0;

        @(negedge clk);
        applyStimulus(row.sel, 1'b1, 1'b0, 1'b1);
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            sampleOut(row.sel, v, idx, d, l, b, dn, ra);
            if (dn) doneCnt++;
            if (!b) begin
                checkOutput("done_at_end", 32'(dn), (abortCyc < 0) ? 32'd1 : 32'd0);
                if (abortCyc >= 0) checkOutput("abort_idle_delay", 32'(cyc - abortCyc), 32'd1);
                else               checkOutput("done_delay", 32'(cyc - lastHsCyc), 32'd1);
                finished = 1'b1;
                break;
            end
            if (v && !firstSeen) begin
                firstSeen = 1'b1;
                checkOutput("first_valid_latency", 32'(cyc), 32'd2);
            end
            r = ($urandom_range(99) < row.readyPct);
            s = 1'b0;
            a = 1'b0;
            if (v) begin
                if (int'(idx) == row.stallIdx && stall < 5) begin
                    r = 1'b0;
                    if (stall == 0) regs[idx] = 32'hDEAD;
                    stall++;
                    if (expQ.size() > 0) begin
                        checkOutput("stall_index", 32'(idx), 32'(expQ[0].idx));
                        checkOutput("stall_data", d, expQ[0].data);
                    end
                end
                if (int'(idx) == row.abortIdx) begin
                    r = 1'b1;
                    a = 1'b1;
                    abortCyc = cyc;
                end
                if (int'(idx) == row.pokeIdx) s = 1'b1;
            end
            if (v && r) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra_beat_index", 32'(idx), 32'hFFFF_FFFF);
                end else begin
                    eb = expQ.pop_front();
                    checkOutput("beat_index", 32'(idx), 32'(eb.idx));
                    checkOutput("beat_data", d, eb.data);
                    checkOutput("beat_last", 32'(l), (eb.idx == 5'd31) ? 32'd1 : 32'd0);
                end
                beats++;
                lastHsCyc = cyc;
            end
            applyStimulus(row.sel, s, a, r);
        end
        if (!finished) checkOutput("scan_timeout", 32'd0, 32'd1);
        applyStimulus(row.sel, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        sampleOut(row.sel, v, idx, d, l, b, dn, ra);
        checkOutput("done_single_cycle", 32'(dn), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        vec_t rr;
        int beats, doneCnt;
        logic v, l, b, dn;
        logic [4:0] idx, ra;
        logic [31:0] d;
        bit found;

        vecs[0] = '{1'b1, 100, -1, -1, -1, 1'b0, 31, 1};
        vecs[1] = '{1'b0, 100, -1, -1, -1, 1'b0, 32, 1};
        vecs[2] = '{1'b1, 100, -1,  7, -1, 1'b0, 31, 1};
        vecs[3] = '{1'b1, 100, 10, -1, -1, 1'b0, 10, 0};
        vecs[4] = '{1'b1, 100, -1, -1,  4, 1'b0, 31, 1};
        vecs[5] = '{1'b1,  60, -1, -1, -1, 1'b1, 31, 1};
        vecs[6] = '{1'b0,  40, -1, -1, -1, 1'b1, 32, 1};
        vecs[7] = '{1'b1,  50, 20, -1, -1, 1'b1, 20, 0};

        preload();
        #12;
        checkAllZero(1'b1, "reset1");
        checkAllZero(1'b0, "reset0");
        @(negedge clk);
        resetn = 1'b1;

        for (int k = 0; k < 8; k++) begin
            preload();
            if (vecs[k].randData) begin
                for (int i = 1; i < 32; i++) regs[i] = $urandom;
            end
            runScan(vecs[k], beats, doneCnt);
            checkOutput($sformatf("row%0d_beats", k), 32'(beats), 32'(vecs[k].expBeats));
            checkOutput($sformatf("row%0d_dones", k), 32'(doneCnt), 32'(vecs[k].expDone));
        end
        preload();

        // start and abort together in IDLE: stays idle
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        sampleOut(1'b1, v, idx, d, l, b, dn, ra);
        checkOutput("start_abort_busy", 32'(b), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        sampleOut(1'b1, v, idx, d, l, b, dn, ra);
        checkOutput("start_abort_valid", 32'(v), 32'd0);

        // abort while in FETCH
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        sampleOut(1'b1, v, idx, d, l, b, dn, ra);
        checkOutput("fetch_busy", 32'(b), 32'd1);
        checkOutput("fetch_raddr", 32'(ra), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        sampleOut(1'b1, v, idx, d, l, b, dn, ra);
        checkOutput("fetch_abort_busy", 32'(b), 32'd0);
        checkOutput("fetch_abort_valid", 32'(v), 32'd0);
        checkOutput("fetch_abort_done", 32'(dn), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

        // asynchronous reset during FETCH of register 3
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            sampleOut(1'b1, v, idx, d, l, b, dn, ra);
            if (b && !v && ra == 5'd3) found = 1'b1;
        end
        checkOutput("reach_fetch3", 32'(found), 32'd1);
        #2 resetn = 1'b0;
        #1 checkAllZero(1'b1, "async_reset");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sampleOut(1'b1, v, idx, d, l, b, dn, ra);
        checkOutput("post_reset_busy", 32'(b), 32'd0);
        rr = '{1'b1, 100, -1, -1, -1, 1'b0, 31, 1};
        runScan(rr, beats, doneCnt);
        checkOutput("restart_beats", 32'(beats), 32'd31);
        checkOutput("restart_dones", 32'(doneCnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
